// File: rtl/exec_stage_pipe.sv
// Execute stage: single-cycle ALU plus branch/jump resolution feeding a
// valid/ready output register. MUL runs on an iterative shift-add engine.
// Build option: define EXEC_MUL_EN to include the multiplier; without it,
// aluop 110 completes in one cycle with alu_out=0 and illegal_op=1.
module exec_stage_pipe #(
   parameter int DATA          = 32,
   parameter int ADDRESSWIDTH  = 32,
   parameter int REGISTERWIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               aluop,
   input  logic                     use_imm,
   input  logic [DATA-1:0]          rs1_data,
   input  logic [DATA-1:0]          rs2_data,
   input  logic [DATA-1:0]          imm,
   input  logic [ADDRESSWIDTH-1:0]  pc_plus4,
   input  logic                     branch_eq,
   input  logic                     branch_ne,
   input  logic                     jump,
   input  logic [REGISTERWIDTH-1:0] rd_in,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA-1:0]          alu_out,
   output logic [DATA-1:0]          write_data,
   output logic [ADDRESSWIDTH-1:0]  new_address,
   output logic                     branch_taken,
   output logic                     overflow,
   output logic                     illegal_op,
   output logic [REGISTERWIDTH-1:0] rd_out,
   output logic                     busy
);

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpSlt  = 3'b101;
   localparam logic [2:0] OpMul  = 3'b110;
   localparam logic [2:0] OpPass = 3'b111;

   // Combinational datapath results
   logic [DATA-1:0]         op_b;
   logic [DATA-1:0]         sum;
   logic [DATA-1:0]         diff;
   logic [DATA-1:0]         alu_res;
   logic [DATA-1:0]         imm_sh;
   logic                    alu_ovf;
   logic                    alu_ill;
   logic                    taken;
   logic [ADDRESSWIDTH-1:0] target;
   logic                    xfer;
   logic                    mul_start;
   logic                    mul_done_load;

   // Output register state
   logic                     out_valid_q, out_valid_d;
   logic [DATA-1:0]          alu_out_q, alu_out_d;
   logic [DATA-1:0]          write_data_q, write_data_d;
   logic [ADDRESSWIDTH-1:0]  new_address_q, new_address_d;
   logic                     branch_taken_q, branch_taken_d;
   logic                     overflow_q, overflow_d;
   logic                     illegal_op_q, illegal_op_d;
   logic [REGISTERWIDTH-1:0] rd_out_q, rd_out_d;

`ifdef EXEC_MUL_EN
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned   CntW     = $clog2(DATA);
   localparam logic [CntW-1:0] LastIter = CntW'(DATA - 1);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DATA-1:0] acc_q, acc_d;
   logic [DATA-1:0] mcand_q, mcand_d;
   logic [DATA-1:0] mplier_q, mplier_d;
`endif

   // ALU, overflow and illegal-op decode
   always_comb begin
      op_b    = use_imm ? imm : rs2_data;
      sum     = rs1_data + op_b;
      diff    = rs1_data - op_b;
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (aluop)
         OpAdd: begin
            alu_res = sum;
            alu_ovf = (rs1_data[DATA-1] == op_b[DATA-1]) && (sum[DATA-1] != rs1_data[DATA-1]);
         end
         OpSub: begin
            alu_res = diff;
            alu_ovf = (rs1_data[DATA-1] != op_b[DATA-1]) && (diff[DATA-1] != rs1_data[DATA-1]);
         end
         OpAnd:  alu_res = rs1_data & op_b;
         OpOr:   alu_res = rs1_data | op_b;
         OpXor:  alu_res = rs1_data ^ op_b;
         OpSlt:  alu_res = {{(DATA-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
         OpMul: begin
`ifdef EXEC_MUL_EN
            // Product comes from the iterative engine, not from this path
            alu_res = '0;
`else
            alu_ill = 1'b1;
`endif
         end
         OpPass: alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   // Branch condition and target address; branches compare against rs2, not operand B
   always_comb begin
      imm_sh = imm << 2;
      taken  = jump || (branch_eq && (rs1_data == rs2_data))
                    || (branch_ne && (rs1_data != rs2_data));
      if (branch_eq || branch_ne) begin
         target = pc_plus4 + imm_sh[ADDRESSWIDTH-1:0];
      end else if (jump) begin
         target = rs1_data[ADDRESSWIDTH-1:0];
      end else begin
         target = '0;
      end
   end

`ifdef EXEC_MUL_EN
   assign busy          = (state_q != StIdle);
   assign mul_start     = xfer && (aluop == OpMul);
   assign mul_done_load = (state_q == StDone) && (!out_valid_q || out_ready);
`else
   assign busy          = 1'b0;
   assign mul_start     = 1'b0;
   assign mul_done_load = 1'b0;
`endif

   assign in_ready = !busy && (!out_valid_q || out_ready);
   assign xfer     = in_valid && in_ready && !flush;

   // Output register next state: drain, load, multiplier completion, flush
   always_comb begin
      out_valid_d    = out_valid_q;
      alu_out_d      = alu_out_q;
      write_data_d   = write_data_q;
      new_address_d  = new_address_q;
      branch_taken_d = branch_taken_q;
      overflow_d     = overflow_q;
      illegal_op_d   = illegal_op_q;
      rd_out_d       = rd_out_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // Side fields of a MUL are captured at issue; only alu_out waits for the engine
      if (xfer) begin
         write_data_d   = rs2_data;
         rd_out_d       = rd_in;
         new_address_d  = target;
         branch_taken_d = taken;
         overflow_d     = alu_ovf;
         illegal_op_d   = alu_ill;
         if (!mul_start) begin
            alu_out_d   = alu_res;
            out_valid_d = 1'b1;
         end
      end
`ifdef EXEC_MUL_EN
      if (mul_done_load) begin
         alu_out_d   = acc_q;
         out_valid_d = 1'b1;
      end
`endif
      if (flush) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q    <= 1'b0;
         alu_out_q      <= '0;
         write_data_q   <= '0;
         new_address_q  <= '0;
         branch_taken_q <= 1'b0;
         overflow_q     <= 1'b0;
         illegal_op_q   <= 1'b0;
         rd_out_q       <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         alu_out_q      <= alu_out_d;
         write_data_q   <= write_data_d;
         new_address_q  <= new_address_d;
         branch_taken_q <= branch_taken_d;
         overflow_q     <= overflow_d;
         illegal_op_q   <= illegal_op_d;
         rd_out_q       <= rd_out_d;
      end
   end

`ifdef EXEC_MUL_EN
   // Shift-add multiplier: one partial product per cycle; the low DATA bits of
   // the unsigned product equal those of the signed product
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      case (state_q)
         StIdle: begin
            if (mul_start) begin
               state_d  = StMul;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = rs1_data;
               mplier_d = op_b;
            end
         end
         StMul: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastIter) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (mul_done_load) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
   end

   // Multiplier state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end
`endif

   assign out_valid    = out_valid_q;
   assign alu_out      = alu_out_q;
   assign write_data   = write_data_q;
   assign new_address  = new_address_q;
   assign branch_taken = branch_taken_q;
   assign overflow     = overflow_q;
   assign illegal_op   = illegal_op_q;
   assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe (DATA=32): a transaction-level model with a
// per-cycle compare process, plus directed literal checks.
module tb_exec_stage_pipe;

   localparam int DATA = 32;
   localparam int AW   = 32;
   localparam int RW   = 5;
`ifdef EXEC_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif
   localparam longint SMax = 64'sd2147483647;
   localparam longint SMin = -64'sd2147483648;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      aluop = '0;
   logic            use_imm = 1'b0;
   logic [DATA-1:0] rs1_data = '0;
   logic [DATA-1:0] rs2_data = '0;
   logic [DATA-1:0] imm = '0;
   logic [AW-1:0]   pc_plus4 = '0;
   logic            branch_eq = 1'b0;
   logic            branch_ne = 1'b0;
   logic            jump = 1'b0;
   logic [RW-1:0]   rd_in = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DATA-1:0] alu_out;
   logic [DATA-1:0] write_data;
   logic [AW-1:0]   new_address;
   logic            branch_taken;
   logic            overflow;
   logic            illegal_op;
   logic [RW-1:0]   rd_out;
   logic            busy;

   always #5 clk = ~clk;

   exec_stage_pipe #(.DATA(DATA), .ADDRESSWIDTH(AW), .REGISTERWIDTH(RW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .use_imm(use_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imm(imm), .pc_plus4(pc_plus4), .branch_eq(branch_eq), .branch_ne(branch_ne),
      .jump(jump), .rd_in(rd_in), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alu_out(alu_out), .write_data(write_data),
      .new_address(new_address), .branch_taken(branch_taken), .overflow(overflow),
      .illegal_op(illegal_op), .rd_out(rd_out), .busy(busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the result register as a record, and a pending MUL as a countdown
   bit            m_valid = 0;
   int            m_left = 0;
   logic [31:0]   m_alu, m_pend, m_wd, m_addr;
   bit            m_ovf, m_ill, m_taken, m_cf;
   logic [RW-1:0] m_rd;
   bit            chk_en = 0;

   always @(posedge clk) begin : model
      logic [31:0] a, b;
      longint      r;
      bit          rdy, xfer;
      if (!reset_n) begin
         m_valid = 0;
         m_left  = 0;
      end else begin
         rdy  = (m_left == 0) && (!m_valid || out_ready);
         xfer = in_valid && rdy && !flush;
         if (m_valid && out_ready) m_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1;
               m_alu   = m_pend;
            end
         end
         if (xfer) begin
            a     = rs1_data;
            b     = use_imm ? imm : rs2_data;
            m_ovf = 0;
            m_ill = 0;
            m_wd  = rs2_data;
            m_rd  = rd_in;
            m_taken = jump || (branch_eq && a == rs2_data) || (branch_ne && a != rs2_data);
            m_cf    = branch_eq || branch_ne || jump;
            if (branch_eq || branch_ne) begin
               r      = longint'(pc_plus4) + 4 * longint'($signed(imm));
               m_addr = r[31:0];
            end else begin
               m_addr = rs1_data;
            end
            case (aluop)
               3'd0: begin
                  r = longint'($signed(a)) + longint'($signed(b));
                  m_alu = r[31:0];
                  m_ovf = (r > SMax) || (r < SMin);
               end
               3'd1: begin
                  r = longint'($signed(a)) - longint'($signed(b));
                  m_alu = r[31:0];
                  m_ovf = (r > SMax) || (r < SMin);
               end
               3'd2: m_alu = a & b;
               3'd3: m_alu = a | b;
               3'd4: m_alu = a ^ b;
               3'd5: m_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               3'd6: begin
                  r = longint'($signed(a)) * longint'($signed(b));
                  if (MulEn) begin
                     m_pend = r[31:0];
                     m_left = DATA + 1;
                  end else begin
                     m_alu = 32'd0;
                     m_ill = 1;
                  end
               end
               default: m_alu = b;
            endcase
            if (!(MulEn && aluop == 3'd6)) m_valid = 1;
         end
         if (flush) begin
            m_valid = 0;
            m_left  = 0;
         end
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, m_valid);
         check("busy", busy, m_left > 0);
         check("in_ready", in_ready, (m_left == 0) && (!m_valid || out_ready));
         if (m_valid) begin
            check("alu_out", alu_out, m_alu);
            check("overflow", overflow, m_ovf);
            check("illegal_op", illegal_op, m_ill);
            check("branch_taken", branch_taken, m_taken);
            check("write_data", write_data, m_wd);
            check("rd_out", rd_out, m_rd);
            if (m_cf) check("new_address", new_address, m_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] op, input logic ui, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                        input logic be, input logic bn, input logic jp, input logic [4:0] rd);
      aluop = op; use_imm = ui; rs1_data = a; rs2_data = b; imm = im; pc_plus4 = pc;
      branch_eq = be; branch_ne = bn; jump = jp; rd_in = rd;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_alu"}, alu_out, 0);
      check({tag, "_wd"}, write_data, 0);
      check({tag, "_addr"}, new_address, 0);
      check({tag, "_taken"}, branch_taken, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_ill"}, illegal_op, 0);
      check({tag, "_rd"}, rd_out, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      tick();
      tick();
      chk_en = 1;
      @(negedge clk);
      check_all_zero("reset");
      #1 reset_n = 1'b1;
      tick();
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);

      #1 issue(3'd0, 0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0, 0, 0, 5'd1);
      @(negedge clk);
      check("add_alu", alu_out, 32'h8000_0000);
      check("add_ovf", overflow, 1);
      check("add_valid", out_valid, 1);

      #1 issue(3'd5, 1, 32'hFFFF_FFFF, 32'h55, 32'h1, 32'h0, 0, 0, 0, 5'd2);
      @(negedge clk);
      check("slt_alu", alu_out, 32'h1);

      #1 issue(3'd1, 0, 32'd5, 32'd7, 32'h0, 32'h0, 0, 0, 0, 5'd3);
      @(negedge clk);
      check("sub_alu", alu_out, 32'hFFFF_FFFE);
      check("sub_ovf", overflow, 0);
      check("sub_wd", write_data, 32'd7);

      #1 issue(3'd0, 0, 32'd3, 32'd3, 32'hFFFF_FFFE, 32'h100, 1, 0, 0, 5'd4);
      @(negedge clk);
      check("beq_taken", branch_taken, 1);
      check("beq_addr", new_address, 32'hF8);

      #1 issue(3'd0, 0, 32'd3, 32'd3, 32'h10, 32'h200, 0, 1, 0, 5'd5);
      @(negedge clk);
      check("bne_taken", branch_taken, 0);

      #1 issue(3'd7, 0, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 1, 5'd6);
      @(negedge clk);
      check("jump_addr", new_address, 32'h400);
      check("jump_taken", branch_taken, 1);

      // Model-only vectors across remaining ops, including SUB overflow
      #1 issue(3'd1, 0, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 0, 0, 0, 5'd7);
      issue(3'd4, 1, 32'hA5A5_A5A5, 32'h0, 32'hFFFF_0000, 32'h0, 0, 0, 0, 5'd8);
      issue(3'd7, 1, 32'h0, 32'h9, 32'h1234_5678, 32'h0, 0, 0, 0, 5'd9);
      issue(3'd3, 1, 32'h0F00, 32'h0, 32'h00F0, 32'h0, 0, 0, 0, 5'd10);
      issue(3'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 5'd11);

      // Backpressure: hold with out_ready low, then drain and reload on the same edge
      issue(3'd2, 0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 0, 0, 0, 5'd12);
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_first", alu_out, 32'hF000);
      #1;
      aluop = 3'd3; use_imm = 0; rs1_data = 32'hF0F0; rs2_data = 32'hFF00; rd_in = 5'd13;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_hold_alu", alu_out, 32'hF000);
         check("bp_hold_valid", out_valid, 1);
      end
      #1 out_ready = 1'b1;
      #1 check("bp_ready_back", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_reload_alu", alu_out, 32'hFFF0);
      check("bp_reload_rd", rd_out, 5'd13);
      check("bp_reload_valid", out_valid, 1);

      // Flush clears a held result and overrides a same-cycle transfer
      #1 out_ready = 1'b0;
      issue(3'd4, 0, 32'h1, 32'h2, 32'h0, 32'h0, 0, 0, 0, 5'd14);
      aluop = 3'd0; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_valid", out_valid, 0);
      #1 out_ready = 1'b1;

`ifdef EXEC_MUL_EN
      issue(3'd6, 0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 0, 0, 0, 5'd15);
      @(negedge clk);
      check("mul_busy_t0", busy, 1);
      for (int k = 1; k <= 32; k++) begin
         tick();
         @(negedge clk);
         check("mul_busy", busy, 1);
         check("mul_no_valid", out_valid, 0);
      end
      tick();
      @(negedge clk);
      check("mul_valid", out_valid, 1);
      check("mul_alu", alu_out, 32'hFFFF_FFEB);
      check("mul_busy_end", busy, 0);
      #1 issue(3'd6, 0, 32'h3, 32'h5, 32'h0, 32'h0, 0, 0, 0, 5'd16);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("mul_flush_busy", busy, 0);
      check("mul_flush_valid", out_valid, 0);
      #1 repeat (35) tick();
      @(negedge clk);
      check("mul_flush_quiet", out_valid, 0);
      #1 issue(3'd6, 1, 32'h3, 32'h0, 32'h5, 32'h0, 0, 0, 0, 5'd17);
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      check("mul_reset_busy", busy, 0);
      #1 reset_n = 1'b1;
      tick();
`else
      issue(3'd6, 0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 0, 0, 0, 5'd15);
      @(negedge clk);
      check("mul_valid", out_valid, 1);
      check("mul_alu", alu_out, 32'h0);
      check("mul_ill", illegal_op, 1);
      check("mul_busy", busy, 0);
      #1;
`endif

      // Reset during an accepted-looking transfer wipes everything
      out_ready = 1'b0;
      issue(3'd7, 1, 32'h0, 32'h77, 32'hCAFE, 32'h0, 0, 0, 1, 5'd18);
      aluop = 3'd0; in_valid = 1'b1; reset_n = 1'b0;
      tick();
      @(negedge clk);
      check_all_zero("rst_mid");
      #1 reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      #1 issue(3'd0, 1, 32'd10, 32'd0, 32'd20, 32'h0, 0, 0, 0, 5'd19);
      @(negedge clk);
      check("post_rst_add", alu_out, 32'd30);
      #1 repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exec_stage_pipe.md
EXEC_STAGE_PIPE -- requirements
Module: exec_stage_pipe

Interface
REQ-001 The parameter list SHALL be: DATA, 32, operand/result width in bits (8..64).
REQ-002 The parameter list SHALL be: ADDRESSWIDTH, 32, PC width; ADDRESSWIDTH <= DATA.
REQ-003 The parameter list SHALL be: REGISTERWIDTH, 5, destination register index width.
REQ-004 The module SHALL have one clock and a synchronous, active-low reset, listed first: clk in 1 clock; reset_n in 1 reset.
REQ-005 The remaining ports SHALL be:
- in_valid  in  1  issue request
- in_ready  out  1  stage can accept
- aluop  in  3  operation select
- use_imm  in  1  operand B = imm when 1, else rs2_data
- rs1_data, rs2_data, imm  in  DATA  operands
- pc_plus4  in  ADDRESSWIDTH  PC of the next instruction
- branch_eq, branch_ne, jump  in  1  control-flow type (one-hot or all zero)
- rd_in  in  REGISTERWIDTH  destination register
- flush  in  1  kill in-flight and registered work
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- alu_out, write_data  out  DATA  result; registered rs2_data
- new_address  out  ADDRESSWIDTH  jump/branch target
- branch_taken, overflow, illegal_op  out  1  flags
- rd_out  out  REGISTERWIDTH  destination register
- busy  out  1  multi-cycle operation in progress

Function
REQ-006 aluop encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1 or 0), 110 MUL (low DATA bits of the signed product), 111 PASSB.
REQ-007 Operand B SHALL be imm when use_imm=1, else rs2_data; operand A SHALL always be rs1_data.
REQ-008 overflow SHALL be the signed two's-complement overflow of ADD/SUB and 0 for all other ops.
REQ-009 branch_taken SHALL be: jump, OR branch_eq AND (A==rs2_data), OR branch_ne AND (A!=rs2_data).
REQ-010 The target SHALL be computed as follows:
- branch_eq or branch_ne: new_address = pc_plus4 + (sign-extended imm << 2), truncated to ADDRESSWIDTH bits (wraps).
- jump: new_address = rs1_data[ADDRESSWIDTH-1:0].
REQ-011 in_ready SHALL equal !busy && (!out_valid || out_ready).
REQ-012 A transfer SHALL occur on a rising edge where in_valid && in_ready && !flush.
REQ-013 For non-MUL ops, all outputs SHALL be registered; out_valid and the results SHALL appear on the edge of the transfer (latency 1).
REQ-014 out_valid SHALL stay set, and the outputs SHALL hold stable, until out_ready=1 at an edge.
REQ-015 On simultaneous out_ready and a new transfer, the register SHALL reload with no bubble.
REQ-016 MUL SHALL follow this state machine: IDLE -> MUL on a MUL transfer; MUL -> DONE after DATA iterations of the shift-add engine; DONE -> IDLE when the result loads into the output register.
REQ-017 busy SHALL equal 1 in MUL and DONE; out_valid for MUL SHALL rise exactly DATA+1 edges after the transfer.
REQ-018 flush SHALL clear out_valid, abort any MUL (state -> IDLE, busy=0), and override a same-cycle transfer; the data registers need not clear.
REQ-019 write_data SHALL be the rs2_data captured at transfer, and rd_out SHALL be rd_in captured at transfer.

Reset
REQ-020 While reset_n=0 at an edge, the following SHALL be 0: out_valid, busy, alu_out, write_data, new_address, branch_taken, overflow, illegal_op, rd_out, and the multiplier counter and state (IDLE).
REQ-021 Reset SHALL take priority over flush and over any transfer, including mid-MUL.
REQ-022 in_ready SHALL be 1 on the first edge after reset_n rises.

Configuration
REQ-023 The feature SHALL be controlled by macro EXEC_MUL_EN.
- Defined: the iterative multiplier of REQ-016/017 is present.
- Undefined: the multiplier logic is absent; busy is tied 0; aluop 110 completes with latency 1 with alu_out=0 and illegal_op=1.
- illegal_op is 0 for all other ops in both builds.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (DATA=32):
- ADD 0x7FFFFFFF+1, use_imm=0 -> next edge alu_out=0x80000000, overflow=1, out_valid=1.
- SLT A=0xFFFFFFFF, B=1 -> alu_out=1; SUB 5-7 -> 0xFFFFFFFE, overflow=0.
- branch_eq, A=rs2=3, pc_plus4=0x100, imm=0xFFFFFFFE -> branch_taken=1, new_address=0xF8; jump, rs1=0x400 -> new_address=0x400, branch_taken=1.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 with in_valid=1 -> reload on the same edge.
- EXEC_MUL_EN defined: MUL 0xFFFFFFFD*7 -> busy for 32 cycles, out_valid at edge 33, alu_out=0xFFFFFFEB; flush at cycle 10 -> busy=0 and no out_valid.
- EXEC_MUL_EN undefined: MUL -> latency 1, alu_out=0, illegal_op=1; reset_n=0 mid-transfer -> all outputs 0.
